// File: rtl/r2_lut_addr_gen.sv
// r^2 -> LJ coefficient ROM address generator with aligned side channel.
// Also streams full-table reloads into the ROM through the write port.
module r2_lut_addr_gen #(
  parameter int DEPTH       = 3072,
  parameter int ADDR_WIDTH  = 12,
  parameter int SEGMENT_NUM = 12,
  parameter int BIN_WIDTH   = 8,
  parameter int MIN_EXP     = 121,
  parameter int LUT_LATENCY = 2,
  parameter int INIT_LOADED = 1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [31:0]           r2,
  input  logic                  r2_valid,
  output logic                  r2_ready,
  input  logic                  load_start,
  input  logic [31:0]           load_data,
  input  logic                  load_valid,
  output logic                  load_done,
  output logic [ADDR_WIDTH-1:0] lut_address,
  output logic [31:0]           lut_data,
  output logic                  lut_rden,
  output logic                  lut_wren,
  output logic [22-BIN_WIDTH:0] frac_out,
  output logic                  pair_valid_out,
  output logic                  out_of_range_out,
  output logic                  underflow_out
);

  localparam int FW = 23 - BIN_WIDTH;
  localparam int SW = ADDR_WIDTH - BIN_WIDTH;
  localparam int ND = 1 + LUT_LATENCY;
  localparam logic [7:0] E_MIN = 8'(MIN_EXP);
  localparam logic [7:0] E_END = 8'(MIN_EXP + SEGMENT_NUM);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_nxt;
  logic   pending, pending_nxt;
  logic   load_fire;
  logic   accept;
  logic   inflight;
  logic [ADDR_WIDTH-1:0] cnt;

  logic [7:0]    e;
  logic [SW-1:0] seg;
  logic          oor_d;
  logic          uf_d;

  logic                  s0_busy, s0_hit, s0_oor, s0_uf;
  logic [FW-1:0]         s0_frac;
  logic [ADDR_WIDTH-1:0] s0_addr;

  logic [ND-1:0] dl_busy, dl_hit, dl_oor, dl_uf;
  logic [FW-1:0] dl_frac [ND];

  assign e      = r2[30:23];
  assign seg    = SW'(e - E_MIN);
  assign oor_d  = r2[31] | (e == 8'hFF) | (e >= E_END);
  assign uf_d   = ~oor_d & (e < E_MIN);
  assign accept = r2_valid & r2_ready;

  assign inflight = s0_busy | (|dl_busy);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    load_fire   = 1'b0;
    r2_ready    = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) state_nxt = LOAD;
      end
      LOAD: begin
        if (load_valid) begin
          load_fire = 1'b1;
          if (cnt == LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        r2_ready = ~pending;
        if (load_start) pending_nxt = 1'b1;
        // Reload only once every in-flight lookup has left the side channel
        if (pending && !inflight) begin
          state_nxt   = LOAD;
          pending_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= (INIT_LOADED != 0) ? RUN : IDLE;
      pending     <= 1'b0;
      cnt         <= '0;
      load_done   <= 1'b0;
      lut_address <= '0;
      lut_data    <= '0;
      lut_rden    <= 1'b0;
      lut_wren    <= 1'b0;
      s0_busy     <= 1'b0;
      s0_hit      <= 1'b0;
      s0_oor      <= 1'b0;
      s0_uf       <= 1'b0;
      s0_frac     <= '0;
      s0_addr     <= '0;
      dl_busy     <= '0;
      dl_hit      <= '0;
      dl_oor      <= '0;
      dl_uf       <= '0;
      for (int i = 0; i < ND; i++) dl_frac[i] <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;

      s0_busy <= accept;
      s0_hit  <= accept & ~oor_d & ~uf_d;
      s0_oor  <= accept & oor_d;
      s0_uf   <= accept & uf_d;
      if (accept) begin
        s0_frac <= r2[FW-1:0];
        s0_addr <= {seg, r2[22 -: BIN_WIDTH]};
      end

      load_done <= load_fire & (cnt == LAST);
      if (load_fire) begin
        cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;
        lut_wren    <= 1'b1;
        lut_rden    <= 1'b0;
        lut_address <= cnt;
        lut_data    <= load_data;
      end else begin
        lut_wren <= 1'b0;
        lut_rden <= s0_hit;
        if (s0_hit) lut_address <= s0_addr;
      end

      dl_busy <= {dl_busy[ND-2:0], s0_busy};
      dl_hit  <= {dl_hit[ND-2:0], s0_hit};
      dl_oor  <= {dl_oor[ND-2:0], s0_oor};
      dl_uf   <= {dl_uf[ND-2:0], s0_uf};
      dl_frac[0] <= s0_frac;
      for (int i = 1; i < ND; i++) dl_frac[i] <= dl_frac[i-1];
    end
  end

  assign frac_out         = dl_frac[ND-1];
  assign pair_valid_out   = dl_hit[ND-1];
  assign out_of_range_out = dl_oor[ND-1];
  assign underflow_out    = dl_uf[ND-1];

endmodule

// File: tb/tb_r2_lut_addr_gen.sv
// Directed bench for r2_lut_addr_gen: lookup timing, range flags,
// table reload, load arbitration with in-flight lookups, reset mid-load.
module tb_r2_lut_addr_gen;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] r2 = '0;
  logic        r2_valid = 1'b0;
  logic        load_start = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_valid = 1'b0;

  logic        r2_ready, load_done, lut_rden, lut_wren;
  logic [11:0] lut_address;
  logic [31:0] lut_data;
  logic [14:0] frac_out;
  logic        pair_valid_out, out_of_range_out, underflow_out;

  logic        p_ready, p_done, p_rden, p_wren;
  logic [11:0] p_addr;
  logic [31:0] p_data;
  logic [14:0] p_frac;
  logic        p_pv, p_oor, p_uf;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  r2_lut_addr_gen #(.INIT_LOADED(0)) dut (
    .clock(clock), .rst(rst), .r2(r2), .r2_valid(r2_valid),
    .r2_ready(r2_ready), .load_start(load_start),
    .load_data(load_data), .load_valid(load_valid),
    .load_done(load_done), .lut_address(lut_address),
    .lut_data(lut_data), .lut_rden(lut_rden), .lut_wren(lut_wren),
    .frac_out(frac_out), .pair_valid_out(pair_valid_out),
    .out_of_range_out(out_of_range_out),
    .underflow_out(underflow_out)
  );

  r2_lut_addr_gen #(.INIT_LOADED(1)) pre (
    .clock(clock), .rst(rst), .r2(r2), .r2_valid(r2_valid),
    .r2_ready(p_ready), .load_start(load_start),
    .load_data(load_data), .load_valid(load_valid),
    .load_done(p_done), .lut_address(p_addr),
    .lut_data(p_data), .lut_rden(p_rden), .lut_wren(p_wren),
    .frac_out(p_frac), .pair_valid_out(p_pv),
    .out_of_range_out(p_oor), .underflow_out(p_uf)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    checks++;
    if ({lut_address, lut_data, lut_rden, lut_wren, load_done, frac_out,
         pair_valid_out, out_of_range_out, underflow_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h data=%h rd=%b wr=%b done=%b",
               lut_address, lut_data, lut_rden, lut_wren, load_done);
    end
    checks++;
    if (r2_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ready got %b exp 0", r2_ready);
    end
    checks++;
    if (p_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_run_ready got %b exp 1", p_ready);
    end
    rst = 1'b0;
    step;
    r2 = 32'h3F800000;
    r2_valid = 1'b1;
    step;
    r2_valid = 1'b0;
    step;
    checks++;
    if ({p_rden, p_addr} !== {1'b1, 12'h600}) begin
      errors++;
      $display("FAIL preloaded_lookup got rd=%b addr=%h exp 1 600",
               p_rden, p_addr);
    end
    checks++;
    if (lut_rden !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_rden got %b exp 0", lut_rden);
    end
    repeat (4) step;
  endtask

  task automatic test_load;
    int gaps [5] = '{5, 100, 1000, 2000, 3000};
    load_start = 1'b1;
    step;
    load_start = 1'b0;
    checks++;
    if (r2_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready got %b exp 0", r2_ready);
    end
    for (int k = 0; k < 3072; k++) begin
      for (int g = 0; g < 5; g++) begin
        if (gaps[g] == k) begin
          load_valid = 1'b0;
          step;
          checks++;
          if (lut_wren !== 1'b0) begin
            errors++;
            $display("FAIL load_gap k=%0d wren got %b exp 0", k, lut_wren);
          end
        end
      end
      load_valid = 1'b1;
      load_data = 32'hA5000000 ^ k;
      step;
      checks++;
      if ({lut_wren, lut_rden, lut_address, lut_data, load_done, r2_ready}
          !== {1'b1, 1'b0, 12'(k), 32'hA5000000 ^ k,
               k == 3071, k == 3071}) begin
        errors++;
        $display("FAIL load_word k=%0d got wr=%b rd=%b a=%h d=%h done=%b rdy=%b",
                 k, lut_wren, lut_rden, lut_address, lut_data,
                 load_done, r2_ready);
      end
    end
    load_valid = 1'b0;
    step;
    checks++;
    if ({load_done, lut_wren, r2_ready} !== 3'b001) begin
      errors++;
      $display("FAIL load_end got done=%b wr=%b rdy=%b exp 0 0 1",
               load_done, lut_wren, r2_ready);
    end
  endtask

  task automatic test_single(input logic [31:0] v, input logic hit,
                             input logic [11:0] a, input logic [14:0] f,
                             input logic o, input logic u);
    r2 = v;
    r2_valid = 1'b1;
    step;
    r2_valid = 1'b0;
    r2 = '0;
    step;
    checks++;
    if (lut_rden !== hit || lut_wren !== 1'b0) begin
      errors++;
      $display("FAIL single_rden r2=%h got rd=%b wr=%b exp rd=%b",
               v, lut_rden, lut_wren, hit);
    end
    if (hit) begin
      checks++;
      if (lut_address !== a) begin
        errors++;
        $display("FAIL single_addr r2=%h got %h exp %h", v, lut_address, a);
      end
    end
    step;
    checks++;
    if ({pair_valid_out, out_of_range_out, underflow_out} !== 3'b000) begin
      errors++;
      $display("FAIL single_early r2=%h got %b%b%b exp 000", v,
               pair_valid_out, out_of_range_out, underflow_out);
    end
    step;
    checks++;
    if ({pair_valid_out, out_of_range_out, underflow_out} !== {hit, o, u}) begin
      errors++;
      $display("FAIL single_flags r2=%h got pv=%b oor=%b uf=%b exp %b %b %b",
               v, pair_valid_out, out_of_range_out, underflow_out, hit, o, u);
    end
    if (hit) begin
      checks++;
      if (frac_out !== f) begin
        errors++;
        $display("FAIL single_frac r2=%h got %h exp %h", v, frac_out, f);
      end
    end
    step;
  endtask

  task automatic test_back_to_back;
    logic [31:0] v [4] = '{32'h3F800000, 32'h3FC00000,
                           32'h42800000, 32'h3F812345};
    logic        h [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [11:0] a [4] = '{12'h600, 12'h680, 12'h000, 12'h602};
    logic [14:0] f [4] = '{15'h0, 15'h0, 15'h0, 15'h2345};
    for (int c = 0; c < 8; c++) begin
      r2_valid = (c < 4);
      r2 = (c < 4) ? v[c] : '0;
      step;
      if (c >= 1 && c <= 4) begin
        checks++;
        if (lut_rden !== h[c-1] || (h[c-1] && lut_address !== a[c-1])) begin
          errors++;
          $display("FAIL b2b_addr i=%0d got rd=%b a=%h exp rd=%b a=%h",
                   c - 1, lut_rden, lut_address, h[c-1], a[c-1]);
        end
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (pair_valid_out !== h[c-3] || out_of_range_out !== !h[c-3] ||
            (h[c-3] && frac_out !== f[c-3])) begin
          errors++;
          $display("FAIL b2b_aligned i=%0d got pv=%b oor=%b fr=%h exp pv=%b fr=%h",
                   c - 3, pair_valid_out, out_of_range_out, frac_out,
                   h[c-3], f[c-3]);
        end
      end
    end
  endtask

  task automatic test_load_pending;
    int first = -1;
    int writes = 0;
    int dones = 0;
    r2 = 32'h3F800000;
    r2_valid = 1'b1;
    step;
    r2 = 32'h3FC00000;
    load_start = 1'b1;
    step;
    r2_valid = 1'b0;
    load_start = 1'b0;
    checks++;
    if (r2_ready !== 1'b0 || lut_rden !== 1'b1 || lut_address !== 12'h600) begin
      errors++;
      $display("FAIL pend_first got rdy=%b rd=%b a=%h exp 0 1 600",
               r2_ready, lut_rden, lut_address);
    end
    step;
    checks++;
    if (lut_rden !== 1'b1 || lut_address !== 12'h680) begin
      errors++;
      $display("FAIL pend_second got rd=%b a=%h exp 1 680",
               lut_rden, lut_address);
    end
    load_valid = 1'b1;
    load_data = 32'h12345678;
    for (int c = 3; c < 40 && first < 0; c++) begin
      step;
      if (c == 3 || c == 4) begin
        checks++;
        if (pair_valid_out !== 1'b1 || frac_out !== 15'h0) begin
          errors++;
          $display("FAIL pend_aligned c=%0d got pv=%b fr=%h exp 1 0",
                   c, pair_valid_out, frac_out);
        end
      end
      if (lut_wren) first = c;
    end
    checks++;
    if (first < 5 || lut_address !== 12'h000) begin
      errors++;
      $display("FAIL pend_first_write got cycle=%0d addr=%h exp >=5 000",
               first, lut_address);
    end
    writes = 1;
    for (int n = 0; n < 4000 && dones == 0; n++) begin
      step;
      if (lut_wren && lut_rden) begin
        errors++;
        $display("FAIL pend_rd_wr_overlap got both high exp exclusive");
      end
      if (lut_wren) writes++;
      if (load_done) dones++;
    end
    load_valid = 1'b0;
    checks++;
    if (writes !== 3072 || dones !== 1 || lut_address !== 12'hBFF) begin
      errors++;
      $display("FAIL pend_reload got writes=%0d dones=%0d last=%h exp 3072 1 bff",
               writes, dones, lut_address);
    end
    step;
    checks++;
    if (r2_ready !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL pend_resume got rdy=%b done=%b exp 1 0",
               r2_ready, load_done);
    end
  endtask

  task automatic test_reset_mid_load;
    load_start = 1'b1;
    step;
    load_start = 1'b0;
    step;
    load_valid = 1'b1;
    repeat (10) step;
    checks++;
    if (lut_wren !== 1'b1 || lut_address !== 12'd9) begin
      errors++;
      $display("FAIL midload_progress got wr=%b a=%h exp 1 009",
               lut_wren, lut_address);
    end
    load_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if ({r2_ready, lut_wren, lut_address, load_done} !== '0) begin
      errors++;
      $display("FAIL midload_reset got rdy=%b wr=%b a=%h done=%b exp all 0",
               r2_ready, lut_wren, lut_address, load_done);
    end
    load_start = 1'b1;
    step;
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 32'hCAFEF00D;
    step;
    load_valid = 1'b0;
    checks++;
    if ({lut_wren, lut_address, lut_data} !== {1'b1, 12'h000, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL midload_restart got wr=%b a=%h d=%h exp 1 000 cafef00d",
               lut_wren, lut_address, lut_data);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_single(32'h3F800000, 1'b1, 12'h600, 15'h0000, 1'b0, 1'b0);
    test_single(32'h3FC00000, 1'b1, 12'h680, 15'h0000, 1'b0, 1'b0);
    test_single(32'h3F812345, 1'b1, 12'h602, 15'h2345, 1'b0, 1'b0);
    test_single(32'h3C800000, 1'b1, 12'h000, 15'h0000, 1'b0, 1'b0);
    test_single(32'h427FFFFF, 1'b1, 12'hBFF, 15'h7FFF, 1'b0, 1'b0);
    test_single(32'h42800000, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b0);
    test_single(32'hBF800000, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b0);
    test_single(32'h7FC00000, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b0);
    test_single(32'h7F800000, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b0);
    test_single(32'h3C000000, 1'b0, 12'h000, 15'h0000, 1'b0, 1'b1);
    test_single(32'h00000000, 1'b0, 12'h000, 15'h0000, 1'b0, 1'b1);
    test_single(32'h00000001, 1'b0, 12'h000, 15'h0000, 1'b0, 1'b1);
    test_back_to_back;
    test_load_pending;
    test_reset_mid_load;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
